imem_fetch_responder: RTL and testbench

// - Instruction-memory responder; it is the far end of the fetch path driven by the PC register.
// - Accepts one word fetch request at a time and returns the stored instruction after a fixed,

---
 rtl/imem_fetch_responder.sv | 125 ++++++++++++
 tb/tb_imem_fetch_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder at the far end of the fetch path.
// Accepts one word fetch at a time, answers after a fixed latency and holds
// the response until the fetch side takes it. Misaligned or out-of-range
// fetches are flagged and answered with NOP_INST. A side load port writes
// program words in any state.
module imem_fetch_responder #(
    parameter int          DEPTH_LOG2 = 6,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_inst,
    output logic                  resp_err,
    input  logic                  load_en,
    input  logic [DEPTH_LOG2-1:0] load_addr,
    input  logic [31:0]           load_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [3:0]            cnt_reg;
    logic [3:0]            cnt_next;
    logic [31:0]           addr_reg;
    logic                  accept;
    logic                  capture;
    logic [31:0]           cap_addr;
    logic                  cap_err;
    logic [DEPTH_LOG2-1:0] cap_idx;

    logic [31:0] mem [DEPTH];

    // Program storage: load port writes in every state, contents never reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    // With a single-cycle latency the capture edge is the accept edge, so the
    // address comes straight from the request port instead of the latch.
    assign cap_addr = (state_reg == IDLE) ? req_addr : addr_reg;
    assign cap_err  = (cap_addr[1:0] != 2'b00) || (cap_addr[31:DEPTH_LOG2+2] != '0);
    assign cap_idx  = cap_addr[DEPTH_LOG2+1:2];

    // Next-state logic: accept in IDLE, count down in BUSY, wait for handshake in RESP.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    accept   = 1'b1;
                    cnt_next = 4'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        capture    = 1'b1;
                    end else begin
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                // Counter was loaded with LATENCY-1 on the accept edge, so it
                // reads zero exactly on edge T+LATENCY.
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, latched address and response registers; the memory read is
    // registered into resp_inst on the edge that enters RESP, so a load on
    // that same edge is not seen.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
            addr_reg  <= 32'd0;
            resp_inst <= 32'd0;
            resp_err  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                addr_reg <= req_addr;
            end
            if (capture) begin
                resp_err  <= cap_err;
                resp_inst <= cap_err ? NOP_INST : mem[cap_idx];
            end
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench for imem_fetch_responder: directed scenarios plus
// randomized fetches checked against a word-array reference model.
module tb_imem_fetch_responder;

    localparam int LAT = 2;

    logic        clk;
    logic        reset;
    logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, resp_inst;
    logic        req_valid1, req_ready1, resp_valid1, resp_ready1, resp_err1;
    logic [31:0] req_addr1, resp_inst1;
    logic        load_en;
    logic [5:0]  load_addr;
    logic [31:0] load_data;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [64];

    imem_fetch_responder #(.DEPTH_LOG2(6), .LATENCY(LAT), .NOP_INST(32'h0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_inst(resp_inst), .resp_err(resp_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    imem_fetch_responder #(.DEPTH_LOG2(6), .LATENCY(1), .NOP_INST(32'h0)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_addr(req_addr1),
        .resp_valid(resp_valid1), .resp_ready(resp_ready1),
        .resp_inst(resp_inst1), .resp_err(resp_err1),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_word(input logic [5:0] idx, input logic [31:0] data);
        load_en = 1'b1; load_addr = idx; load_data = data;
        @(posedge clk); #1;
        load_en = 1'b0;
        model_mem[idx] = data;
    endtask

    function automatic logic is_err(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'd256);
    endfunction

    // One fetch on the LATENCY=2 instance. load_at>0 places a load on edge
    // T+load_at relative to the accept edge T.
    task automatic do_fetch(input logic [31:0] a, input int stall, input int load_at,
                            input logic [5:0] ld_idx, input logic [31:0] ld_data);
        logic [31:0] exp_inst;
        logic        exp_err;
        int          lat;
        exp_err = is_err(a);
        if (exp_err) exp_inst = 32'h0;
        else if (load_at >= 1 && load_at < LAT && ld_idx == 6'(a / 4)) exp_inst = ld_data;
        else exp_inst = model_mem[a / 4];
        check("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_addr = a;
        @(posedge clk); #1;
        req_valid = 1'b0; req_addr = $urandom;
        lat = 0;
        while (!resp_valid && lat < 40) begin
            if (lat + 1 == load_at) begin
                load_en = 1'b1; load_addr = ld_idx; load_data = ld_data;
            end
            @(posedge clk); #1;
            load_en = 1'b0;
            lat++;
        end
        if (load_at >= 1) model_mem[ld_idx] = ld_data;
        check("latency", 32'(lat), 32'(LAT));
        check("resp_inst", resp_inst, exp_inst);
        check("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
        check("req_ready_resp", {31'd0, req_ready}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check("stall_valid", {31'd0, resp_valid}, 32'd1);
            check("stall_inst", resp_inst, exp_inst);
            check("stall_err", {31'd0, resp_err}, {31'd0, exp_err});
            check("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("after_hs_valid", {31'd0, resp_valid}, 32'd0);
        check("after_hs_req_ready", {31'd0, req_ready}, 32'd1);
        check("after_hs_inst_hold", resp_inst, exp_inst);
        $display("fetch addr=%h inst=%h err=%0d lat=%0d stall=%0d", a, resp_inst, resp_err, lat, stall);
    endtask

    logic [31:0] b2b [3];
    int          acc_cyc [3];
    int          n_acc, n_resp, cyc, seen, w;
    bit          acc_now;
    logic [31:0] ra;

    initial begin
        reset = 1'b1;
        req_valid = 0; req_addr = 0; resp_ready = 0;
        req_valid1 = 0; req_addr1 = 0; resp_ready1 = 1;
        load_en = 0; load_addr = 0; load_data = 0;
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        check("rst_resp_inst", resp_inst, 32'd0);
        check("rst_req_ready1", {31'd0, req_ready1}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 64; i++) load_word(6'(i), $urandom);
        load_word(6'd0, 32'h11111111);
        load_word(6'd1, 32'h22222222);
        load_word(6'd2, 32'h33333333);
        load_word(6'd3, 32'h44444444);

        // basic fetch, stalled fetch, error fetches
        do_fetch(32'h4, 0, 0, 6'd0, 32'h0);
        do_fetch(32'h8, 5, 0, 6'd0, 32'h0);
        do_fetch(32'h6, 0, 0, 6'd0, 32'h0);
        do_fetch(32'h100, 1, 0, 6'd0, 32'h0);

        // reset one cycle after accept
        req_valid = 1'b1; req_addr = 32'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #3;
        reset = 1'b1; #1;
        check("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_resp_inst", resp_inst, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        check("midrst_no_resp", 32'(seen), 32'd0);
        $display("reset during BUSY: late responses=%0d", seen);

        // reset while holding a response: drop must be asynchronous
        req_valid = 1'b1; req_addr = 32'h4;
        @(posedge clk); #1;
        req_valid = 1'b0;
        w = 0;
        while (!resp_valid && w < 20) begin @(posedge clk); #1; w++; end
        check("resp_before_rst", {31'd0, resp_valid}, 32'd1);
        #2 reset = 1'b1; #1;
        check("resprst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("resprst_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen++;
        end
        check("resprst_no_resp", 32'(seen), 32'd0);
        $display("reset during RESP: late responses=%0d", seen);

        // load collision around the capture edge
        do_fetch(32'hC, 0, 1, 6'd3, 32'hDEADBEEF);
        load_word(6'd3, 32'h44444444);
        do_fetch(32'hC, 0, 2, 6'd3, 32'hDEADBEEF);
        do_fetch(32'hC, 0, 0, 6'd0, 32'h0);

        // back-to-back on the LATENCY=1 instance
        b2b[0] = 32'h0; b2b[1] = 32'h4; b2b[2] = 32'h8;
        for (int i = 0; i < 3; i++) acc_cyc[i] = 0;
        n_acc = 0; n_resp = 0; cyc = 0;
        req_valid1 = 1'b1; req_addr1 = b2b[0];
        while (n_resp < 3 && cyc < 30) begin
            acc_now = req_valid1 && req_ready1;
            if (resp_valid1) begin
                check("b2b_inst", resp_inst1, model_mem[b2b[n_resp] / 4]);
                check("b2b_err", {31'd0, resp_err1}, 32'd0);
                $display("b2b resp %0d inst=%h cycle=%0d", n_resp, resp_inst1, cyc);
                n_resp++;
            end
            @(posedge clk); cyc++; #1;
            if (acc_now && n_acc < 3) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 3) req_valid1 = 1'b0;
                else req_addr1 = b2b[n_acc];
            end
        end
        req_valid1 = 1'b0;
        check("b2b_count", 32'(n_resp), 32'd3);
        check("b2b_space01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd2);
        check("b2b_space12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd2);

        // randomized fetches against the model
        for (int n = 0; n < 30; n++) begin
            case ($urandom_range(0, 3))
                0, 1:    ra = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                2:       ra = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
                default: ra = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) load_word(6'($urandom_range(0, 63)), $urandom);
            do_fetch(ra, $urandom_range(0, 3), 0, 6'd0, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
